// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin arbiter that shares one combinational ALU
// between NUM_REQ integer-issue requesters. The selected operation is
// evaluated and captured in a single result register. That register is
// presented to writeback with a valid/ready handshake.
//
// Ports:
//   clk, reset                    clock, async active-high reset
//   req_valid/op/in1/in2/tag      packed per-requester operation (slice i = req i)
//   req_ready                     one-hot grant
//   flush                         drop held result, block grants this cycle
//   out_valid/ready               result handshake
//   out_result/tag/src            registered result, dest tag, requester index

`ifndef XPR_LEN
`define XPR_LEN 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD  4'd0
`define ALU_OP_SLL  4'd1
`define ALU_OP_XOR  4'd4
`define ALU_OP_SRL  4'd5
`define ALU_OP_OR   4'd6
`define ALU_OP_AND  4'd7
`define ALU_OP_SEQ  4'd8
`define ALU_OP_SNE  4'd9
`define ALU_OP_SUB  4'd10
`define ALU_OP_SRA  4'd11
`define ALU_OP_SLT  4'd12
`define ALU_OP_SGE  4'd13
`define ALU_OP_SLTU 4'd14
`define ALU_OP_SGEU 4'd15
`endif

module alu (
  input  logic [`ALU_OP_WIDTH-1:0] op,
  input  logic [`XPR_LEN-1:0]      in1,
  input  logic [`XPR_LEN-1:0]      in2,
  output logic [`XPR_LEN-1:0]      out
);
  localparam int unsigned XW = `XPR_LEN;
  logic [4:0] shamt;

  always_comb begin
    shamt = in2[4:0];
    case (op)
      `ALU_OP_ADD:  out = in1 + in2;
      `ALU_OP_SLL:  out = in1 << shamt;
      `ALU_OP_XOR:  out = in1 ^ in2;
      `ALU_OP_OR:   out = in1 | in2;
      `ALU_OP_AND:  out = in1 & in2;
      `ALU_OP_SRL:  out = in1 >> shamt;
      `ALU_OP_SEQ:  out = {{(XW-1){1'b0}}, (in1 == in2)};
      `ALU_OP_SNE:  out = {{(XW-1){1'b0}}, (in1 != in2)};
      `ALU_OP_SUB:  out = in1 - in2;
      `ALU_OP_SRA:  out = $signed(in1) >>> shamt;
      `ALU_OP_SLT:  out = {{(XW-1){1'b0}}, ($signed(in1) < $signed(in2))};
      `ALU_OP_SGE:  out = {{(XW-1){1'b0}}, ($signed(in1) >= $signed(in2))};
      `ALU_OP_SLTU: out = {{(XW-1){1'b0}}, (in1 < in2)};
      `ALU_OP_SGEU: out = {{(XW-1){1'b0}}, (in1 >= in2)};
      default:      out = '0;
    endcase
  end
endmodule

module alu_issue_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned SRC_W   = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*`ALU_OP_WIDTH-1:0]  req_op,
  input  logic [NUM_REQ*`XPR_LEN-1:0]       req_in1,
  input  logic [NUM_REQ*`XPR_LEN-1:0]       req_in2,
  input  logic [NUM_REQ*TAG_W-1:0]          req_tag,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic                              flush,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [`XPR_LEN-1:0]               out_result,
  output logic [TAG_W-1:0]                  out_tag,
  output logic [SRC_W-1:0]                  out_src
);
  localparam int unsigned OPW = `ALU_OP_WIDTH;
  localparam int unsigned XW  = `XPR_LEN;

  logic [OPW-1:0]   op_arr  [NUM_REQ];
  logic [XW-1:0]    in1_arr [NUM_REQ];
  logic [XW-1:0]    in2_arr [NUM_REQ];
  logic [TAG_W-1:0] tag_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign op_arr[gi]  = req_op[gi*OPW +: OPW];
    assign in1_arr[gi] = req_in1[gi*XW +: XW];
    assign in2_arr[gi] = req_in2[gi*XW +: XW];
    assign tag_arr[gi] = req_tag[gi*TAG_W +: TAG_W];
  end

  logic             out_valid_q, out_valid_d;
  logic [XW-1:0]    out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [SRC_W-1:0] out_src_q, out_src_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             slot_free, can_grant, found;
  logic [SRC_W:0]   scan_idx;
  logic [SRC_W-1:0] gnt_idx;
  logic [XW-1:0]    alu_out;

  // Scan starts at rr_ptr and wraps modulo NUM_REQ; scan_idx carries one
  // extra bit so the wrap works for non-power-of-two NUM_REQ.
  always_comb begin
    slot_free = !out_valid_q || out_ready;
    can_grant = slot_free && !flush && !reset;
    found     = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    if (can_grant) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        scan_idx = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
        if (scan_idx >= (SRC_W+1)'(NUM_REQ))
          scan_idx = scan_idx - (SRC_W+1)'(NUM_REQ);
        if (!found && req_valid[scan_idx[SRC_W-1:0]]) begin
          found   = 1'b1;
          gnt_idx = scan_idx[SRC_W-1:0];
        end
      end
    end
    req_ready = found ? (NUM_REQ'(1) << gnt_idx) : '0;
  end

  alu u_alu (
    .op  (op_arr[gnt_idx]),
    .in1 (in1_arr[gnt_idx]),
    .in2 (in2_arr[gnt_idx]),
    .out (alu_out)
  );

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    out_src_d    = out_src_q;
    rr_ptr_d     = rr_ptr_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (found) begin
      out_valid_d  = 1'b1;
      out_result_d = alu_out;
      out_tag_d    = tag_arr[gnt_idx];
      out_src_d    = gnt_idx;
      if ({1'b0, gnt_idx} == (SRC_W+1)'(NUM_REQ - 1))
        rr_ptr_d = '0;
      else
        rr_ptr_d = gnt_idx + SRC_W'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_src_q    <= '0;
      rr_ptr_q     <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      out_src_q    <= out_src_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign out_src    = out_src_q;
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed testbench for alu_issue_arbiter (NUM_REQ=2, TAG_W=6, SRC_W=1).
// Inputs are driven on the falling edge; outputs are sampled #1 later.

`ifndef XPR_LEN
`define XPR_LEN 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD  4'd0
`define ALU_OP_SLL  4'd1
`define ALU_OP_XOR  4'd4
`define ALU_OP_SRL  4'd5
`define ALU_OP_OR   4'd6
`define ALU_OP_AND  4'd7
`define ALU_OP_SEQ  4'd8
`define ALU_OP_SNE  4'd9
`define ALU_OP_SUB  4'd10
`define ALU_OP_SRA  4'd11
`define ALU_OP_SLT  4'd12
`define ALU_OP_SGE  4'd13
`define ALU_OP_SLTU 4'd14
`define ALU_OP_SGEU 4'd15
`endif

module tb_alu_issue_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [7:0]  req_op;
  logic [63:0] req_in1, req_in2;
  logic [11:0] req_tag;
  logic [1:0]  req_ready;
  logic        flush, out_valid, out_ready;
  logic [31:0] out_result;
  logic [5:0]  out_tag;
  logic [0:0]  out_src;

  int errors = 0;
  int checks = 0;

  alu_issue_arbiter #(.NUM_REQ(2), .TAG_W(6), .SRC_W(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_in1(req_in1), .req_in2(req_in2), .req_tag(req_tag),
    .req_ready(req_ready), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
    .out_src(out_src)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [5:0] t);
    req_valid[i]        = v;
    req_op[i*4 +: 4]    = op;
    req_in1[i*32 +: 32] = a;
    req_in2[i*32 +: 32] = b;
    req_tag[i*6 +: 6]   = t;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    req_valid = 2'b11; req_op = '0; req_in1 = '0; req_in2 = '0; req_tag = '0;
    #3;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", out_result); end
    @(negedge clk);
    reset = 1'b0; req_valid = 2'b00;
  endtask

  task automatic test_single();
    set_req(0, 1'b1, `ALU_OP_SUB, 32'd5, 32'd7, 6'h12);
    out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", req_ready); end
    @(posedge clk); @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
    checks++; if (out_result !== 32'hFFFFFFFE) begin errors++; $display("FAIL single_result: got %h want fffffffe", out_result); end
    checks++; if (out_tag !== 6'h12) begin errors++; $display("FAIL single_tag: got %h want 12", out_tag); end
    checks++; if (out_src !== 1'b0) begin errors++; $display("FAIL single_src: got %0d want 0", out_src); end
    req_valid = 2'b00;
  endtask

  // Result from req0 is still live here; reset must clear it without an edge.
  task automatic test_reset_midstream();
    #1 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", out_valid); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL midreset_result: got %h want 0", out_result); end
    checks++; if (out_tag !== 6'h0) begin errors++; $display("FAIL midreset_tag: got %h want 0", out_tag); end
    checks++; if (out_src !== 1'b0) begin errors++; $display("FAIL midreset_src: got %0d want 0", out_src); end
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_res;
    logic        exp_src;
    exp_res = '0; exp_src = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c < 4) begin
        set_req(0, 1'b1, `ALU_OP_ADD, 32'(c), 32'd100, 6'h01);
        set_req(1, 1'b1, `ALU_OP_XOR, 32'(c), 32'hFF, 6'h02);
      end else begin
        req_valid = 2'b00;
      end
      #1;
      if (c > 0) begin
        checks++; if (out_src !== exp_src) begin errors++; $display("FAIL rr_src%0d: got %0d want %0d", c, out_src, exp_src); end
        checks++; if (out_result !== exp_res) begin errors++; $display("FAIL rr_result%0d: got %h want %h", c, out_result, exp_res); end
      end
      if (c < 4) begin
        checks++;
        if (req_ready !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
          errors++; $display("FAIL rr_grant%0d: got %b want %b", c, req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
        end
        exp_src = (c % 2 != 0);
        exp_res = (c % 2 == 0) ? 32'(c) + 32'd100 : 32'(c) ^ 32'hFF;
      end
      @(posedge clk); @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_pressure();
    set_req(0, 1'b1, `ALU_OP_ADD, 32'd10, 32'd20, 6'h05);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid[0] = 1'b0;
    out_ready = 1'b0;
    set_req(1, 1'b1, `ALU_OP_SUB, 32'd100, 32'd1, 6'h07);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready%0d: got %b want 00", c, req_ready); end
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'd30 || out_tag !== 6'h05 || out_src !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b r=%h t=%h s=%0d want v=1 r=0000001e t=05 s=0",
                           c, out_valid, out_result, out_tag, out_src);
      end
      @(posedge clk); @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_release_ready: got %b want 10", req_ready); end
    @(posedge clk); @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd99 || out_tag !== 6'h07 || out_src !== 1'b1) begin
      errors++; $display("FAIL bp_replace: got v=%b r=%h t=%h s=%0d want v=1 r=00000063 t=07 s=1",
                         out_valid, out_result, out_tag, out_src);
    end
    req_valid = 2'b00;
  endtask

  // rr_ptr is 0 entering this test; both requesters are offered after the
  // flush so a grant taken during the flush cycle would steer to req1.
  task automatic test_flush();
    out_ready = 1'b0;
    flush = 1'b1;
    set_req(0, 1'b1, `ALU_OP_ADD, 32'd1, 32'd2, 6'h03);
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL flush_ready: got %b want 00", req_ready); end
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    set_req(1, 1'b1, `ALU_OP_ADD, 32'd40, 32'd2, 6'h04);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL flush_rr: got %b want 01", req_ready); end
    @(posedge clk); @(negedge clk);
    req_valid = 2'b00;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd3 || out_src !== 1'b0) begin
      errors++; $display("FAIL flush_after: got v=%b r=%h s=%0d want v=1 r=00000003 s=0", out_valid, out_result, out_src);
    end
  endtask

  task automatic test_op_sweep();
    logic [3:0]  ops [13];
    logic [31:0] a   [13];
    logic [31:0] b   [13];
    logic [31:0] exp [13];
    ops[0]  = `ALU_OP_SRA;  a[0]  = 32'h80000000; b[0]  = 32'd4;        exp[0]  = 32'hF8000000;
    ops[1]  = `ALU_OP_SLTU; a[1]  = 32'd1;        b[1]  = 32'hFFFFFFFF; exp[1]  = 32'd1;
    ops[2]  = `ALU_OP_SGE;  a[2]  = 32'hFFFFFFFF; b[2]  = 32'd0;        exp[2]  = 32'd0;
    ops[3]  = `ALU_OP_SEQ;  a[3]  = 32'd7;        b[3]  = 32'd7;        exp[3]  = 32'd1;
    ops[4]  = `ALU_OP_SNE;  a[4]  = 32'd7;        b[4]  = 32'd7;        exp[4]  = 32'd0;
    ops[5]  = `ALU_OP_SGEU; a[5]  = 32'd0;        b[5]  = 32'd1;        exp[5]  = 32'd0;
    ops[6]  = `ALU_OP_SLT;  a[6]  = 32'hFFFFFFFF; b[6]  = 32'd0;        exp[6]  = 32'd1;
    ops[7]  = `ALU_OP_SLL;  a[7]  = 32'd3;        b[7]  = 32'd4;        exp[7]  = 32'h30;
    ops[8]  = `ALU_OP_SRL;  a[8]  = 32'h80000000; b[8]  = 32'd4;        exp[8]  = 32'h08000000;
    ops[9]  = `ALU_OP_AND;  a[9]  = 32'hF0F0;     b[9]  = 32'hFF00;     exp[9]  = 32'hF000;
    ops[10] = `ALU_OP_OR;   a[10] = 32'hF0F0;     b[10] = 32'hFF00;     exp[10] = 32'hFFF0;
    ops[11] = 4'd2;         a[11] = 32'd5;        b[11] = 32'd6;        exp[11] = 32'd0;
    ops[12] = `ALU_OP_SUB;  a[12] = 32'd0;        b[12] = 32'd1;        exp[12] = 32'hFFFFFFFF;
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      set_req(1, 1'b1, ops[i], a[i], b[i], 6'(i));
      #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL sweep_ready%0d: got %b want 10", i, req_ready); end
      @(posedge clk); @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_result !== exp[i] || out_tag !== 6'(i) || out_src !== 1'b1) begin
        errors++; $display("FAIL sweep_result%0d: got v=%b r=%h t=%h s=%0d want v=1 r=%h t=%h s=1",
                           i, out_valid, out_result, out_tag, out_src, exp[i], 6'(i));
      end
    end
    req_valid = 2'b00;
    @(posedge clk); @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sweep_drain: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_midstream();
    test_round_robin();
    test_back_pressure();
    test_flush();
    test_op_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
Shares one combinational ALU datapath (one `alu` instance inside this block) between NUM_REQ integer-issue requesters, such as reservation-station select ports. Arbitration is round-robin. The selected operation is evaluated and captured in a single output register. That register presents the result with its destination tag to the writeback/CDB stage under a valid/ready handshake. A flush input kills in-flight work on misprediction.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
TAG_W, 6, destination rename-tag width (RRF index)
SRC_W, 1, requester index width; must equal max(1, clog2(NUM_REQ))

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester operation valid
req_op  in  NUM_REQ*`ALU_OP_WIDTH  per-requester ALU op, slice i = requester i
req_in1  in  NUM_REQ*`XPR_LEN  operand 1 per requester
req_in2  in  NUM_REQ*`XPR_LEN  operand 2 per requester
req_tag  in  NUM_REQ*TAG_W  destination tag per requester
req_ready  out  NUM_REQ  one-hot grant; requester i accepted when req_valid[i] & req_ready[i]
flush  in  1  kill: drop held result, no grant this cycle
out_valid  out  1  result register holds a live result
out_ready  in  1  consumer accepts result this cycle
out_result  out  `XPR_LEN  ALU result
out_tag  out  TAG_W  destination tag of result
out_src  out  SRC_W  index of requester that produced result

Behaviour:
- Reset (async, active-high) clears the following, all immediately: out_valid=0, out_result=0, out_tag=0, out_src=0, rr_ptr=0. req_ready=0 while reset is asserted.
- slot_free = !out_valid | out_ready.
- can_grant = slot_free & !flush & !reset.
- Grant (combinational): when can_grant, req_ready is one-hot on the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ. Otherwise req_ready=0.
- req_ready must not depend on any requester's req_valid other than through the scan itself; no combinational path from out_result.
- On accept of requester g at a rising edge:
  - out_result <= alu(req_op[g], req_in1[g], req_in2[g]), covering all ALU ops including SEQ/SNE/SGE/SGEU compare ops.
  - out_tag <= req_tag[g]; out_src <= g; out_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
- Latency is exactly 1 cycle from accept to out_valid. Throughput is 1 op/cycle when out_ready stays high.
- No accept and out_valid & out_ready: out_valid <= 0. Data fields hold their last value.
- Back-pressure: while out_valid & !out_ready, out_result, out_tag and out_src are held stable, and req_ready=0.
- Simultaneous drain and accept (out_valid & out_ready & a grant): the new result replaces the old in the same edge; out_valid stays 1.
- flush=1: out_valid <= 0 at the next edge regardless of out_ready. No grant that cycle; rr_ptr unchanged. Results presented in the flush cycle are not considered consumed by this block.
- No requests: rr_ptr unchanged.
- Fairness: a continuously valid requester is granted within NUM_REQ grants.
- Undefined op codes produce out_result=0, matching the ALU default.

Test Plan:
- Reset mid-stream: out_valid=1, assert reset asynchronously -> out_valid, out_result, out_tag, out_src all 0 before next edge; first grant after release goes to req 0.
- Single request: req0 op=`ALU_OP_SUB, in1=5, in2=7, tag=6'h12, out_ready=1 -> req_ready=2'b01; next cycle out_valid=1, out_result=32'hFFFFFFFE, out_tag=6'h12, out_src=0.
- Round-robin: both requesters valid every cycle for 4 cycles, out_ready=1 -> grants 0,1,0,1, with out_src following one cycle later.
- Back-pressure: result held with out_ready=0 for 3 cycles, req1 valid -> req_ready=0 and outputs stable for 3 cycles. Raise out_ready -> req1 granted that cycle; new result appears next edge with out_valid staying 1.
- Flush: out_valid=1, out_ready=0, req0 valid, flush=1 -> req_ready=0; next cycle out_valid=0, and rr_ptr is unchanged (req0 granted next cycle).
- Op sweep through the arbiter on req1: `ALU_OP_SRA with in1=32'h80000000, in2=4 -> 32'hF8000000; `ALU_OP_SLTU with in1=1, in2=32'hFFFFFFFF -> 1; `ALU_OP_SGE with in1=32'hFFFFFFFF, in2=0 -> 0.
